xcm_clk_div: RTL

Parametrised multi-channel clock-enable generator for the XCM1 clock tree. It derives NUM_CH independent divided clocks and single-cycle clock enables from the board reference clock. Each channel has its own runtime-programmable divide ratio and phase offset, and the block provides a settle-based `locked` indication. It sits beside the fixed PLL and serves low-rate consumers (UART, display scan, timers) that need reprogramming without resynthesis.

---
 rtl/xcm_clk_div.sv | 115 +++++++++++
 1 files changed

// File: rtl/xcm_clk_div.sv
// rtl/xcm_clk_div.sv - multi-channel programmable clock-enable generator with settle-based lock
module xcm_clk_div #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              cfg_last,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outce,
  output logic              locked
);

  typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [31:0]      SETTLE_RST = 32'(LOCK_CYCLES);

  state_t           state;
  logic [31:0]      settle_cnt;
  logic [DIV_W-1:0] div_q    [NUM_CH];
  logic [DIV_W-1:0] sdiv_q   [NUM_CH];
  logic [DIV_W-1:0] sphase_q [NUM_CH];
  logic [DIV_W-1:0] cnt_q    [NUM_CH];
  logic [31:0]      ch_ext;
  logic             xfer;

  assign ch_ext = 32'(cfg_ch);
  assign xfer   = cfg_valid & cfg_ready & (state == LOCKED);

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state      <= SETTLE;
      settle_cnt <= SETTLE_RST;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= DIV_RST;
        sdiv_q[i]   <= DIV_RST;
        sphase_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_q[i] == '0 || cnt_q[i] == div_q[i] - ONE)
          cnt_q[i] <= '0;
        else
          cnt_q[i] <= cnt_q[i] + ONE;
      end
      case (state)
        SETTLE: begin
          if (settle_cnt == 32'd1) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 32'd1;
          end
        end
        LOCKED: begin
          if (xfer) begin
            // Out-of-range channel words are consumed without touching any shadow.
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch_ext == 32'(i)) begin
                sdiv_q[i]   <= cfg_div;
                sphase_q[i] <= cfg_phase;
              end
            end
            if (cfg_last) begin
              state     <= APPLY;
              locked    <= 1'b0;
              cfg_ready <= 1'b0;
            end
          end
        end
        APPLY: begin
          // Every channel reloads, so unchanged channels realign to their phase too.
          for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= sdiv_q[i];
            cnt_q[i] <= (sphase_q[i] < sdiv_q[i]) ? sphase_q[i] : '0;
          end
          settle_cnt <= SETTLE_RST;
          state      <= SETTLE;
        end
        default: begin
          state      <= SETTLE;
          settle_cnt <= SETTLE_RST;
          locked     <= 1'b0;
          cfg_ready  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    outclk = '0;
    outce  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (locked && div_q[i] != '0) begin
        outce[i]  = (cnt_q[i] == div_q[i] - ONE);
        outclk[i] = ({1'b0, cnt_q[i]} < (({1'b0, div_q[i]} + 1'b1) >> 1));
      end
    end
  end

endmodule
